// File: rtl/servo_pkg.sv
// Shared definitions for the servo command path: state encoding, mode constants,
// the PWM frame length shared with the generator, and the slew-limited track step.
package servo_pkg;

    localparam int FRAME_CYCLES_DEF = 20001;

    localparam logic MODE_TRACK = 1'b0;
    localparam logic MODE_SWEEP = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE       = 2'd0,
        ST_TRACK      = 2'd1,
        ST_SWEEP_UP   = 2'd2,
        ST_SWEEP_DOWN = 2'd3
    } state_t;

    // Move cur toward tgt by at most step; differences are taken in 9 bits so
    // nothing wraps and the result never overshoots tgt.
    function automatic logic [7:0] track_next(input logic [7:0] cur,
                                              input logic [7:0] tgt,
                                              input logic [8:0] step);
        logic [8:0] diff;
        if (tgt >= cur) begin
            diff = {1'b0, tgt} - {1'b0, cur};
            return (diff <= step) ? tgt : cur + step[7:0];
        end
        diff = {1'b0, cur} - {1'b0, tgt};
        return (diff <= step) ? tgt : cur - step[7:0];
    endfunction

endpackage

// File: rtl/frame_tick_gen.sv
// Free-running frame counter; frame_tick marks the last cycle of each frame.
module frame_tick_gen
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES = FRAME_CYCLES_DEF
) (
    input  logic clk,
    input  logic rst,
    output logic frame_tick
);

    localparam int CW = (FRAME_CYCLES > 1) ? $clog2(FRAME_CYCLES) : 1;
    localparam logic [CW-1:0] LAST = CW'(FRAME_CYCLES - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else
            cnt <= (cnt == LAST) ? '0 : cnt + CW'(1);
    end

    assign frame_tick = (cnt == LAST);

endmodule

// File: rtl/servo_duty_ramp.sv
// Slew-limited servo duty command: tracks a target or sweeps between limits,
// updating only on frame boundaries every FRAMES_PER_STEP frames.
module servo_duty_ramp
    import servo_pkg::*;
#(
    parameter int FRAME_CYCLES    = FRAME_CYCLES_DEF,
    parameter int FRAMES_PER_STEP = 2,
    parameter int STEP            = 4,
    parameter int SWEEP_MIN       = 0,
    parameter int SWEEP_MAX       = 255,
    parameter int RESET_DUTY      = 128
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       enable,
    input  logic       mode,
    input  logic [7:0] target,
    output logic [7:0] duty_cycle,
    output logic       frame_tick,
    output logic       at_target,
    output logic       moving
);

    localparam int SW = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;
    localparam logic [SW-1:0] STEP_LAST = SW'(FRAMES_PER_STEP - 1);
    localparam logic [8:0] STEP9 = 9'(STEP);
    localparam logic [8:0] MIN9  = 9'(SWEEP_MIN);
    localparam logic [8:0] MAX9  = 9'(SWEEP_MAX);

    logic [SW-1:0] step_cnt;
    logic          step_evt;
    state_t        state, state_d, eff;
    logic [7:0]    duty_d;
    logic [8:0]    duty9, sw_up, sw_dn;

    frame_tick_gen #(.FRAME_CYCLES(FRAME_CYCLES)) u_frame (
        .clk        (clk),
        .rst        (rst),
        .frame_tick (frame_tick)
    );

    assign step_evt = frame_tick && (step_cnt == STEP_LAST);

    // Held clear while disabled so a re-enable always waits a full step interval.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            step_cnt <= '0;
        else if (!enable)
            step_cnt <= '0;
        else if (frame_tick)
            step_cnt <= step_evt ? '0 : step_cnt + SW'(1);
    end

    // Sweep candidates clamp into [MIN, MAX] first, so an out-of-range entry
    // value lands on the nearest limit in one update.
    assign duty9 = {1'b0, duty_cycle};
    always_comb begin
        if (duty9 < MIN9)
            sw_up = MIN9;
        else if (duty9 + STEP9 >= MAX9)
            sw_up = MAX9;
        else
            sw_up = duty9 + STEP9;

        if (duty9 > MAX9)
            sw_dn = MAX9;
        else if (duty9 <= MIN9 + STEP9)
            sw_dn = MIN9;
        else
            sw_dn = duty9 - STEP9;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            state <= ST_IDLE;
        else
            state <= state_d;
    end

    // At a step event the mode picks the state whose update applies on this
    // edge; the sweep direction after the update follows the new value.
    always_comb begin
        state_d = state;
        duty_d  = duty_cycle;
        eff     = state;
        if (!enable) begin
            state_d = ST_IDLE;
        end else if (step_evt) begin
            if (mode == MODE_TRACK)
                eff = ST_TRACK;
            else if (state == ST_SWEEP_UP || state == ST_SWEEP_DOWN)
                eff = state;
            else
                eff = (duty9 >= MAX9) ? ST_SWEEP_DOWN : ST_SWEEP_UP;

            case (eff)
                ST_TRACK: begin
                    duty_d  = track_next(duty_cycle, target, STEP9);
                    state_d = ST_TRACK;
                end
                ST_SWEEP_UP: begin
                    duty_d  = sw_up[7:0];
                    state_d = (sw_up == MAX9) ? ST_SWEEP_DOWN : ST_SWEEP_UP;
                end
                ST_SWEEP_DOWN: begin
                    duty_d  = sw_dn[7:0];
                    state_d = (sw_dn == MIN9) ? ST_SWEEP_UP : ST_SWEEP_DOWN;
                end
                default: begin
                    duty_d  = duty_cycle;
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            duty_cycle <= 8'(RESET_DUTY);
            moving     <= 1'b0;
            at_target  <= 1'b0;
        end else if (!enable) begin
            moving     <= 1'b0;
            at_target  <= 1'b0;
        end else if (step_evt) begin
            duty_cycle <= duty_d;
            moving     <= (duty_d != duty_cycle);
            at_target  <= (state_d == ST_TRACK) && (duty_d == target);
        end
    end

endmodule

// File: tb/tb_servo_duty_ramp.sv
// Directed bench: three short-frame instances cover track, sweep limits,
// multi-frame step interval, enable drop on a step event, and async reset.
module tb_servo_duty_ramp;

    logic clk = 1'b0;
    logic rst = 1'b1;

    logic       en_a = 0, mode_a = 0;
    logic [7:0] tgt_a = 0;
    logic [7:0] duty_a;
    logic       tick_a, at_a, mov_a;

    logic       en_b = 0, mode_b = 0;
    logic [7:0] tgt_b = 0;
    logic [7:0] duty_b;
    logic       tick_b, at_b, mov_b;

    logic       en_c = 0, mode_c = 0;
    logic [7:0] tgt_c = 0;
    logic [7:0] duty_c;
    logic       tick_c, at_c, mov_c;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    servo_duty_ramp #(.FRAME_CYCLES(10), .FRAMES_PER_STEP(1), .STEP(4)) u_a (
        .clk(clk), .rst(rst), .enable(en_a), .mode(mode_a), .target(tgt_a),
        .duty_cycle(duty_a), .frame_tick(tick_a), .at_target(at_a), .moving(mov_a));

    servo_duty_ramp #(.FRAME_CYCLES(10), .FRAMES_PER_STEP(1), .STEP(4),
                      .SWEEP_MIN(120), .SWEEP_MAX(130)) u_b (
        .clk(clk), .rst(rst), .enable(en_b), .mode(mode_b), .target(tgt_b),
        .duty_cycle(duty_b), .frame_tick(tick_b), .at_target(at_b), .moving(mov_b));

    servo_duty_ramp #(.FRAME_CYCLES(10), .FRAMES_PER_STEP(3), .STEP(4)) u_c (
        .clk(clk), .rst(rst), .enable(en_c), .mode(mode_c), .target(tgt_c),
        .duty_cycle(duty_c), .frame_tick(tick_c), .at_target(at_c), .moving(mov_c));

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d t=%0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    logic [7:0] sweep_exp [8] = '{8'd130, 8'd126, 8'd122, 8'd120, 8'd124, 8'd128, 8'd130, 8'd126};

    initial begin
        tick(3);
        rst = 1'b0;                       // cycle 0 starts here
        chk("rst_duty", duty_a, 128);
        chk("rst_tick", tick_a, 0);
        chk("rst_moving", mov_a, 0);
        chk("rst_at", at_a, 0);

        // disabled: duty frozen, frame_tick every 10th cycle
        for (int k = 0; k < 50; k++) begin
            chk("idle_tick", tick_a, (k % 10) == 9);
            chk("idle_duty", duty_a, 128);
            tick(1);
        end

        // track 128 -> 140
        en_a = 1; mode_a = 0; tgt_a = 140;
        tick(10); chk("trk_132", duty_a, 132); chk("trk_mov1", mov_a, 1); chk("trk_at0", at_a, 0);
        tick(10); chk("trk_136", duty_a, 136);
        tick(10); chk("trk_140", duty_a, 140); chk("trk_at1", at_a, 1); chk("trk_mov2", mov_a, 1);
        tick(10); chk("trk_hold", duty_a, 140); chk("trk_mov0", mov_a, 0); chk("trk_at2", at_a, 1);

        // down to 2, then 2 -> 0 without wrapping
        tgt_a = 2;
        tick(10); chk("dn_136", duty_a, 136);
        tick(340); chk("dn_2", duty_a, 2); chk("dn_at", at_a, 1);
        tgt_a = 0;
        tick(10); chk("zero", duty_a, 0); chk("zero_mov", mov_a, 1);
        tick(10); chk("zero_hold", duty_a, 0); chk("zero_mov0", mov_a, 0); chk("zero_at", at_a, 1);

        // sweep between 120 and 130 from 128
        en_b = 1; mode_b = 1;
        for (int i = 0; i < 8; i++) begin
            tick(10);
            chk("sweep", duty_b, sweep_exp[i]);
            chk("sweep_mov", mov_b, 1);
            chk("sweep_at", at_b, 0);
        end

        // three frames per step; target change mid-interval waits for the event
        en_c = 1; mode_c = 0; tgt_c = 200;
        tick(10); chk("fps_f1", duty_c, 128);
        tick(10); chk("fps_f2", duty_c, 128);
        tick(10); chk("fps_f3", duty_c, 132);
        tick(10); chk("fps_f4", duty_c, 132);
        tick(10); chk("fps_f5", duty_c, 132);
        tick(10); chk("fps_f6", duty_c, 136);
        tick(5);  tgt_c = 100;
        tick(5);  chk("fps_mid1", duty_c, 136);
        tick(10); chk("fps_mid2", duty_c, 136);
        tick(10); chk("fps_new", duty_c, 132); chk("fps_at", at_c, 0);

        // enable dropped on a step-event cycle, then reset mid-ramp
        tgt_a = 200;
        tick(10); chk("ramp_4", duty_a, 4);
        tick(10); chk("ramp_8", duty_a, 8);
        tick(9);  chk("evt_tick", tick_a, 1);
        en_a = 0;
        tick(1);  chk("drop_duty", duty_a, 8); chk("drop_mov", mov_a, 0);
        en_a = 1;
        tick(10); chk("reen_12", duty_a, 12);
        tick(9);  chk("pre_rst_tick", tick_a, 1);
        rst = 1'b1;
        #1;
        chk("arst_duty", duty_a, 128);
        chk("arst_tick", tick_a, 0);
        chk("arst_mov", mov_a, 0);
        chk("arst_at", at_a, 0);
        tick(1);
        rst = 1'b0;
        tick(9);  chk("post_rst_hold", duty_a, 128); chk("post_rst_tick", tick_a, 1);
        tick(1);  chk("post_rst_132", duty_a, 132); chk("post_rst_mov", mov_a, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
